// File: rtl/dot_seq.sv
// rtl/dot_seq.sv - sequential dot-product sequencer driving an external MAC; optional overflow flag via DOT_SEQ_OVF_FLAG_EN
module mac_unit #(
   parameter int IN_WIDTH  = 8,
   parameter int ACC_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [IN_WIDTH-1:0]  a,
   input  logic [IN_WIDTH-1:0]  b,
   input  logic [ACC_WIDTH-1:0] acc_in,
   output logic [ACC_WIDTH-1:0] acc_out
);
   // Registered multiply-accumulate; wraps mod 2^ACC_WIDTH and holds while en is low
   always_ff @(posedge clk) begin
      if (rst)
         acc_out <= '0;
      else if (en)
         acc_out <= acc_in + ACC_WIDTH'(a) * ACC_WIDTH'(b);
   end
endmodule

module dot_seq #(
   parameter int IN_WIDTH  = 8,
   parameter int ACC_WIDTH = 16,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_a,
   input  logic [IN_WIDTH-1:0]  in_b,
   input  logic                 in_last,
   input  logic [ACC_WIDTH-1:0] in_bias,
   output logic [IN_WIDTH-1:0]  mac_a,
   output logic [IN_WIDTH-1:0]  mac_b,
   output logic [ACC_WIDTH-1:0] mac_acc_in,
   output logic                 mac_en,
   input  logic [ACC_WIDTH-1:0] mac_acc_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_ovf
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t               state, next_state;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 first_beat;

   assign mac_a      = in_a;
   assign mac_b      = in_b;
   assign mac_en     = in_valid & in_ready;
   assign first_beat = mac_en & (state == IDLE);
   assign out_data   = mac_acc_out;
   assign out_count  = cnt;

   // State register; reset abandons any partial vector
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state and handshake outputs; the MAC is seeded from bias only on the first beat
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      mac_acc_in = mac_acc_out;
      case (state)
         IDLE: begin
            in_ready   = 1'b1;
            mac_acc_in = in_bias;
            if (in_valid)
               next_state = in_last ? DONE : ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && in_last)
               next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Beat counter: loads 1 on the first beat, saturates at all-ones
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (first_beat)
         cnt <= CNT_WIDTH'(1);
      else if (mac_en && cnt != {CNT_WIDTH{1'b1}})
         cnt <= cnt + CNT_WIDTH'(1);
   end

`ifdef DOT_SEQ_OVF_FLAG_EN
   localparam int SUM_W = ((ACC_WIDTH > 2 * IN_WIDTH) ? ACC_WIDTH : 2 * IN_WIDTH) + 1;

   logic [SUM_W-1:0] full_sum;
   logic             carry;
   logic             ovf_flag;

   assign full_sum = SUM_W'(mac_acc_in) + SUM_W'(in_a) * SUM_W'(in_b);
   assign carry    = (full_sum >> ACC_WIDTH) != '0;
   assign out_ovf  = out_valid & ovf_flag;

   // Sticky wrap flag, restarted with each vector
   always_ff @(posedge clk) begin
      if (rst)
         ovf_flag <= 1'b0;
      else if (first_beat)
         ovf_flag <= carry;
      else if (mac_en)
         ovf_flag <= ovf_flag | carry;
   end
`else
   assign out_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_dot_seq.sv
// tb/tb_dot_seq.sv - randomized self-checking bench for dot_seq with a behavioural MAC
module tb_dot_seq;
   localparam int IW = 8;
   localparam int AW = 16;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [IW-1:0] in_a = '0;
   logic [IW-1:0] in_b = '0;
   logic          in_last = 1'b0;
   logic [AW-1:0] in_bias = '0;
   logic [IW-1:0] mac_a, mac_b;
   logic [AW-1:0] mac_acc_in, mac_acc_out;
   logic          mac_en;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [AW-1:0] out_data;
   logic [CW-1:0] out_count;
   logic          out_ovf;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef DOT_SEQ_OVF_FLAG_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   dot_seq #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_last(in_last), .in_bias(in_bias),
      .mac_a(mac_a), .mac_b(mac_b), .mac_acc_in(mac_acc_in), .mac_en(mac_en),
      .mac_acc_out(mac_acc_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_ovf(out_ovf)
   );

   mac_unit #(.IN_WIDTH(IW), .ACC_WIDTH(AW)) mac (
      .clk(clk), .rst(rst), .en(mac_en), .a(mac_a), .b(mac_b),
      .acc_in(mac_acc_in), .acc_out(mac_acc_out)
   );

   task automatic beat(input logic [IW-1:0] a, input logic [IW-1:0] b,
                       input logic last, input logic [AW-1:0] bias);
      in_valid = 1'b1; in_a = a; in_b = b; in_last = last; in_bias = bias;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      in_bias = 16'hBEEF;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      n_cmp++; if (out_count !== 8'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", out_count); end
      n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %0b want 0", out_ovf); end
      n_cmp++; if (mac_acc_out !== 16'h0) begin n_bad++; $display("FAIL reset_mac_acc got %0h want 0", mac_acc_out); end
      n_cmp++; if (mac_acc_in !== 16'hBEEF) begin n_bad++; $display("FAIL idle_acc_in got %0h want beef", mac_acc_in); end
      n_cmp++; if (mac_en !== 1'b0) begin n_bad++; $display("FAIL idle_mac_en got %0b want 0", mac_en); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      beat(8'd10, 8'd20, 1'b0, 16'd100);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got %0b want 0", out_valid); end
      beat(8'd5, 8'd4, 1'b1, 16'hAAAA);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency got %0b want 1", out_valid); end
      n_cmp++; if (out_data !== 16'd320) begin n_bad++; $display("FAIL basic_data got %0d want 320", out_data); end
      n_cmp++; if (out_count !== 8'd2) begin n_bad++; $display("FAIL basic_count got %0d want 2", out_count); end
      n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf got %0b want 0", out_ovf); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_return_idle got v=%0b r=%0b want v=0 r=1", out_valid, in_ready); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      beat(8'd10, 8'd20, 1'b0, 16'd100);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++; if (mac_en !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bubble_hold got en=%0b r=%0b want en=0 r=1", mac_en, in_ready); end
         @(posedge clk); #1;
      end
      beat(8'd5, 8'd4, 1'b1, 16'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'd320 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_hold got v=%0b d=%0d r=%0b want v=1 d=320 r=0", out_valid, out_data, in_ready); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_last = 1'b1;
      @(negedge clk);
      n_cmp++; if (mac_en !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL handshake_no_accept got en=%0b r=%0b want 0 0", mac_en, in_ready); end
      n_cmp++; if (out_data !== 16'd320) begin n_bad++; $display("FAIL handshake_data got %0d want 320", out_data); end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got %0b want 0", out_valid); end
   endtask

   task automatic test_single();
      out_ready = 1'b0;
      beat(8'd3, 8'd3, 1'b1, 16'd7);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'd16 || out_count !== 8'd1) begin
         n_bad++; $display("FAIL single got v=%0b d=%0d c=%0d want 1 16 1", out_valid, out_data, out_count); end
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      beat(8'h01, 8'hFF, 1'b1, 16'hFFFF);
      @(negedge clk);
      n_cmp++; if (out_data !== 16'h00FE) begin n_bad++; $display("FAIL ovf_data got %0h want fe", out_data); end
      n_cmp++; if (out_ovf !== OVF_EN) begin n_bad++; $display("FAIL ovf_flag got %0b want %0b", out_ovf, OVF_EN); end
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
      beat(8'd1, 8'd1, 1'b1, 16'd1);
      @(negedge clk);
      n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_cleared got %0b want 0", out_ovf); end
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      beat(8'd10, 8'd20, 1'b0, 16'd0);
      do_reset();
      in_bias = 16'd0;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 8'd0) begin
         n_bad++; $display("FAIL rst_mid got r=%0b v=%0b c=%0d want 1 0 0", in_ready, out_valid, out_count); end
      beat(8'd2, 8'd3, 1'b1, 16'd0);
      @(negedge clk);
      n_cmp++; if (out_data !== 16'd6 || out_count !== 8'd1) begin
         n_bad++; $display("FAIL rst_mid_vec got d=%0d c=%0d want 6 1", out_data, out_count); end
      do_reset();
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || out_ovf !== 1'b0) begin
         n_bad++; $display("FAIL rst_in_done got v=%0b o=%0b want 0 0", out_valid, out_ovf); end
   endtask

   // Runs one vector of n beats against the arithmetic model and checks the result
   task automatic run_vector(input int n, input int max_gap, input int max_hold, input string tag);
      longint acc;
      bit     ovf;
      int     exp_cnt;
      logic [IW-1:0] a, b;
      logic [AW-1:0] bias;
      bias = AW'($urandom);
      acc = longint'(bias); ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         a = IW'($urandom); b = IW'($urandom);
         acc = acc + longint'(a) * longint'(b);
         if (acc >= 65536) begin ovf = 1'b1; acc = acc % 65536; end
         beat(a, b, (i == n - 1), (i == 0) ? bias : AW'($urandom));
         if (i != n - 1) idle($urandom_range(0, max_gap));
      end
      exp_cnt = (n > 255) ? 255 : n;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== AW'(acc) || out_count !== CW'(exp_cnt) || out_ovf !== (OVF_EN & ovf)) begin
         n_bad++; $display("FAIL %s n=%0d got v=%0b d=%0h c=%0d o=%0b want 1 %0h %0d %0b",
                           tag, n, out_valid, out_data, out_count, out_ovf, AW'(acc), exp_cnt, OVF_EN & ovf); end
      repeat ($urandom_range(0, max_hold)) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b1 || out_data !== AW'(acc)) begin
            n_bad++; $display("FAIL %s_hold got v=%0b d=%0h want 1 %0h", tag, out_valid, out_data, AW'(acc)); end
      end
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int v = 0; v < 30; v++)
         run_vector($urandom_range(1, 6), 2, 3, "rand");
   endtask

   task automatic test_saturation();
      run_vector(300, 0, 0, "sat");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_single();
      test_overflow();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
